// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the MIPS core's instruction memory.
// Receives an image over UART (8N1, LSB first), assembles big-endian 32-bit
// words and writes them sequentially into imem. The core is held in reset
// until the whole image has been written.
// Image format: CNT_HI, CNT_LO (word count N), then N*4 bytes, MSB first.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds one trailing byte
// that must equal the XOR of all data bytes.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W + 1)'(1);

  // ---------------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  rx_state_t      rx_state;
  rx_state_t      rx_next;
  logic           rx_meta;
  logic           rx_s;
  logic           rx_q;
  logic [CW-1:0]  bit_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     rx_shift;

  // byte_valid is a one-cycle strobe; rx_byte is valid only in that cycle.
  // There is no backpressure: the consumer must take the byte when it pulses.
  // frame_err is a one-cycle strobe raised instead of byte_valid on a low stop bit.
  logic           byte_valid;
  logic [7:0]     rx_byte;
  logic           frame_err;

  logic tick_half;
  logic tick_full;
  assign tick_half = (bit_cnt == CNT_HALF);
  assign tick_full = (bit_cnt == CNT_FULL);

  // Two-stage synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_q    <= rx_s;
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // RX next state: start on falling edge, recheck start at half bit, 8 bits, stop.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_q && !rx_s) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_s ? RX_IDLE : RX_BITS;
      RX_BITS:  if (tick_full && (bit_idx == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX datapath: bit timing, LSB-first shift, byte/framing strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          bit_cnt <= '0;
          bit_idx <= '0;
        end
        RX_START: begin
          if (tick_half) bit_cnt <= '0;
          else           bit_cnt <= bit_cnt + CNT_ONE;
        end
        RX_BITS: begin
          if (tick_full) begin
            bit_cnt  <= '0;
            bit_idx  <= bit_idx + 3'd1;
            rx_shift <= {rx_s, rx_shift[7:1]};
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            bit_cnt <= '0;
            if (rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RUN,
    S_ERR
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = S_CSUM;
`else
  localparam state_t POST_DATA = S_RUN;
`endif

  state_t           state;
  state_t           state_next;
  logic [7:0]       cnt_hi;
  logic [15:0]      word_cnt;
  logic [ADDR_W:0]  waddr;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_q;
  logic             wr_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  logic [15:0] count_n;
  logic        count_too_big;
  assign count_n       = {cnt_hi, rx_byte};
  assign count_too_big = (32'(count_n) > (32'd1 << ADDR_W));

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Loader next state; a framing error anywhere but RUN is fatal.
  always_comb begin
    state_next = state;
    if (frame_err && (state != S_RUN)) begin
      state_next = S_ERR;
    end else begin
      case (state)
        S_IDLE:   if (byte_valid) state_next = S_CNT_LO;
        S_CNT_LO: begin
          if (byte_valid) begin
            if (count_too_big)        state_next = S_ERR;
            else if (count_n == 16'd0) state_next = POST_DATA;
            else                       state_next = S_DATA;
          end
        end
        // Leave DATA only after the final write strobe has been issued, so the
        // core is released one cycle after its last instruction lands.
        S_DATA:   if (imem_we && wr_last) state_next = POST_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM:   if (byte_valid) state_next = (rx_byte == csum) ? S_RUN : S_ERR;
`endif
        S_RUN:    state_next = S_RUN;
        S_ERR:    state_next = S_ERR;
        default:  state_next = S_ERR;
      endcase
    end
  end

  // Loader datapath: count capture, word assembly, write strobe and address.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi     <= '0;
      word_cnt   <= '0;
      waddr      <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      wr_last    <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_IDLE: if (byte_valid) cnt_hi <= rx_byte;
        S_CNT_LO: begin
          if (byte_valid) begin
            word_cnt <= count_n;
            waddr    <= '0;
            byte_idx <= '0;
            wr_last  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            asm_q    <= {asm_q[15:0], rx_byte};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= waddr[ADDR_W-1:0];
              imem_wdata <= {asm_q, rx_byte};
              waddr      <= waddr + ADDR_ONE;
              wr_last    <= ((32'(waddr) + 32'd1) == 32'(word_cnt));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cpu_rst = (state != S_RUN);
  assign done    = (state == S_RUN);
  assign err     = (state == S_ERR);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy    = (state == S_CNT_LO) || (state == S_DATA) || (state == S_CSUM);
`else
  assign busy    = (state == S_CNT_LO) || (state == S_DATA);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of whole-image loads plus hand-written
// sequences for start-bit glitch rejection and reset in the middle of a load.
// Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  localparam int CLKS   = 16;
  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic              rxd;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(
    .CLKS_PER_BIT(CLKS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  initial forever #5 clk = ~clk;

  int chk_total = 0;
  int chk_pass  = 0;
  int wr_count  = 0;
  int cyc       = 0;
  int last_we_cyc   = 0;
  int done_rise_cyc = 0;
  logic done_q = 1'b0;

  logic [ADDR_W+31:0] exp_q[$];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr_count      = 0;
    last_we_cyc   = 0;
    done_rise_cyc = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_total++;
    if (act === exp) chk_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLKS) @(negedge clk);
    end
    rxd = stop;
    repeat (CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (CLKS) @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [ADDR_W+31:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && imem_we) begin
        last_we_cyc = cyc;
        wr_count++;
        chk_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL write: unexpected write addr %0h data %0h", imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({imem_addr, imem_wdata} === e) chk_pass++;
          else $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                        imem_addr, imem_wdata, e[ADDR_W+31:32], e[31:0]);
        end
      end
      if (done && !done_q) done_rise_cyc = cyc;
      done_q = done;
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]           nb;
    logic [0:11][7:0]     b;
    logic [3:0]           bad_idx;
    logic                 has_csum;
    logic [7:0]           csum;
    logic [1:0]           nw;
    logic [1:0][ADDR_W+31:0] wr;
    logic                 exp_done;
    logic                 exp_err;
  } vec_t;

  function automatic vec_t mk(input int nb, input logic [95:0] bytes, input logic [3:0] bad,
                              input logic hc, input logic [7:0] cs, input logic [1:0] nw,
                              input logic [ADDR_W+31:0] w0, input logic [ADDR_W+31:0] w1,
                              input logic d, input logic e);
    vec_t v;
    v.nb       = 4'(nb);
    v.b        = bytes << (8 * (12 - nb));
    v.bad_idx  = bad;
    v.has_csum = hc;
    v.csum     = cs;
    v.nw       = nw;
    v.wr[0]    = w0;
    v.wr[1]    = w1;
    v.exp_done = d;
    v.exp_err  = e;
    return v;
  endfunction

  task automatic send_image(input vec_t v);
    for (int k = 0; k < int'(v.nb); k++)
      send_byte(v.b[k], (k != int'(v.bad_idx)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (v.has_csum) send_byte(v.csum, 1'b1);
`endif
    repeat (4 * CLKS) @(negedge clk);
  endtask

  vec_t vecs[6];

  initial begin
    rst = 1'b1;
    rxd = 1'b1;

    // two-word program
    vecs[0] = mk(10, 96'h0002_2401_0005_AC01_0000, 4'hF, 1'b1, 8'h8D, 2'd2,
                 {12'h000, 32'h24010005}, {12'h001, 32'hAC010000}, 1'b1, 1'b0);
    // empty image
    vecs[1] = mk(2, 96'h0000, 4'hF, 1'b1, 8'h00, 2'd0, '0, '0, 1'b1, 1'b0);
    // count 0x1001 exceeds 4096 words
    vecs[2] = mk(6, 96'h1001_1122_3344, 4'hF, 1'b0, 8'h00, 2'd0, '0, '0, 1'b0, 1'b1);
    // framing error on third data byte (stream index 4)
    vecs[3] = mk(6, 96'h0001_DEAD_BEEF, 4'd4, 1'b0, 8'h00, 2'd0, '0, '0, 1'b0, 1'b1);
    // one word, correct checksum
    vecs[4] = mk(6, 96'h0001_0000_00FF, 4'hF, 1'b1, 8'hFF, 2'd1,
                 {12'h000, 32'h000000FF}, '0, 1'b1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    // same word, wrong checksum: word is written but core stays in reset
    vecs[5] = mk(6, 96'h0001_0000_00FF, 4'hF, 1'b1, 8'hFE, 2'd1,
                 {12'h000, 32'h000000FF}, '0, 1'b0, 1'b1);
`else
    vecs[5] = mk(6, 96'h0001_1234_5678, 4'hF, 1'b1, 8'h08, 2'd1,
                 {12'h000, 32'h12345678}, '0, 1'b1, 1'b0);
`endif

    // reset state
    do_reset();
    check("rst_we", 64'(imem_we), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);

    // table-driven image loads
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int w = 0; w < int'(vecs[i].nw); w++) exp_q.push_back(vecs[i].wr[w]);
      send_image(vecs[i]);
      check($sformatf("v%0d_writes", i), 64'(wr_count), 64'(vecs[i].nw));
      check($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_cpu_rst", i), 64'(cpu_rst), 64'(!vecs[i].exp_done));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("v%0d_pending", i), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      if (i == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("release_after_last_we", 64'(done_rise_cyc > last_we_cyc), 64'd1);
`else
        check("release_latency", 64'(done_rise_cyc - last_we_cyc), 64'd1);
`endif
      end
    end

    // start-bit glitch is discarded, following image loads normally
    do_reset();
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
    check("glitch_busy", 64'(busy), 64'd0);
    exp_q.push_back({12'h000, 32'h12345678});
    send_image(mk(6, 96'h0001_1234_5678, 4'hF, 1'b1, 8'h08, 2'd1, '0, '0, 1'b1, 1'b0));
    check("glitch_writes", 64'(wr_count), 64'd1);
    check("glitch_done", 64'(done), 64'd1);
    exp_q.delete();

    // reset after 6 of 8 data bytes, then a fresh one-word image
    do_reset();
    exp_q.push_back({12'h000, 32'h24010005});
    send_image(mk(8, 96'h0002_2401_0005_AC01, 4'hF, 1'b0, 8'h00, 2'd0, '0, '0, 1'b0, 1'b0));
    check("mid_writes", 64'(wr_count), 64'd1);
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_cpu_rst", 64'(cpu_rst), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_addr", 64'(imem_addr), 64'd0);
    check("mid_rst_wdata", 64'(imem_wdata), 64'd0);
    check("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
    rst = 1'b0;
    wr_count = 0;
    exp_q.delete();
    exp_q.push_back({12'h000, 32'hCAFEF00D});
    send_image(mk(6, 96'h0001_CAFE_F00D, 4'hF, 1'b1, 8'hC9, 2'd1, '0, '0, 1'b1, 1'b0));
    check("reload_writes", 64'(wr_count), 64'd1);
    check("reload_done", 64'(done), 64'd1);
    check("reload_cpu_rst", 64'(cpu_rst), 64'd0);
    check("reload_pending", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
